// File: rtl/fifo_salida_mux_pkg.sv
// Shared definitions for the fifo_salida_mux block: default geometry,
// flag thresholds and a depth helper used by the top, the storage array
// and the bus interface.
package fifo_salida_mux_pkg;

    localparam int DEF_DATA_WIDTH = 8;  // matches the mux data_out width
    localparam int DEF_ADDR_WIDTH = 3;  // 8 entries
    localparam int DEF_AFULL_THR  = 6;  // almost_full when count >= this
    localparam int DEF_AEMPTY_THR = 2;  // almost_empty when count <= this

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_salida_mux_if.sv
// Bus interface for fifo_salida_mux.
//   Producer/consumer side (master): drives data_in, valid_in, pop.
//   FIFO side (slave): drives data_out, valid_out, the level flags, the
//   sticky error flags and the count debug view.
// Handshake: a word is pushed on any rising edge where valid_in is high and
// the FIFO is not full (or a pop happens on the same edge). A word is popped
// on any rising edge where pop is high and the FIFO is not empty; the popped
// word appears on data_out with valid_out high for exactly the following
// cycle. There is no back-pressure on the output side.
interface fifo_salida_mux_if
    import fifo_salida_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;
    logic [ADDR_WIDTH:0]   count;        // occupancy, exposed for debug/checkers

    modport master (
        output data_in, valid_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err, count
    );

    modport slave (
        input  data_in, valid_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err, count
    );

endinterface

// File: rtl/fifo_salida_mux_mem.sv
// Storage array for fifo_salida_mux: DEPTH x DATA_WIDTH registers with one
// synchronous write port and one combinational read port. Storage has no
// reset; stale words are never visible because the pointers/count gate reads.
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
module fifo_salida_mux_mem
    import fifo_salida_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_salida_mux.sv
// Synchronous FIFO sitting behind the 2:1 mux-with-memory. Absorbs the
// mux data_out/outValid stream and lets the downstream PCIe-side stage pop
// at its own pace, with level flags for upstream flow control.
//   clk   in  single clock, all state on the rising edge
//   reset in  asynchronous active-high reset, clears all state except storage
//   bus   slave side of fifo_salida_mux_if (data/valid in, pop, registered
//         data_out/valid_out, full/empty/almost flags, sticky error flags,
//         count debug view)
module fifo_salida_mux
    import fifo_salida_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_THR  = DEF_AFULL_THR,
    parameter int AEMPTY_THR = DEF_AEMPTY_THR
) (
    input logic               clk,
    input logic               reset,
    fifo_salida_mux_if.slave  bus
);
    localparam int            CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  full_w;
    logic                  empty_w;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags decode from the registered count only.
    assign full_w  = (count == DEPTH_C);
    assign empty_w = (count == '0);

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count >= AFULL_C);
    assign bus.almost_empty = (count <= AEMPTY_C);
    assign bus.count        = count;

    // A push into a full FIFO is accepted when a pop frees the slot on the
    // same edge; the read port sees the old word because the array write
    // only lands at the edge.
    assign push_ok = bus.valid_in && (!full_w || bus.pop);
    assign pop_ok  = bus.pop && !empty_w;

    fifo_salida_mux_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            bus.data_out      <= '0;
            bus.valid_out     <= 1'b0;
            bus.overflow_err  <= 1'b0;
            bus.underflow_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr       <= rd_ptr + 1'b1;
                bus.data_out <= rd_word;
            end
            bus.valid_out <= pop_ok;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Both error flags are sticky until reset.
            if (bus.valid_in && full_w && !bus.pop) begin
                bus.overflow_err <= 1'b1;
            end
            if (bus.pop && empty_w) begin
                bus.underflow_err <= 1'b1;
            end
        end
    end

endmodule
